usb_tx_fifo: RTL



---
 rtl/usb_tx_pkg.sv | 15 +
 rtl/usb_tx_fifo_if.sv | 30 +++
 rtl/usb_pkt_len_queue.sv | 49 ++++
 rtl/usb_tx_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types for the USB transmit FIFO.
//   usb_word_t - 16-bit data word moved between the producer and the transmitter
//   tx_state_e - transmit sequencer states
package usb_tx_pkg;

    typedef logic [15:0] usb_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/usb_tx_fifo_if.sv
// usb_tx_fifo_if: producer/transmitter bus of the USB transmit FIFO.
//   master - producer and transmitter side (drives writes, commits, pops)
//   slave  - the FIFO (drives head word, status and start pulse)
interface usb_tx_fifo_if;
    import usb_tx_pkg::*;

    usb_word_t wr_data;
    logic      write_enable;
    logic      packet_commit;
    logic      packet_abort;
    logic      read_enable;
    usb_word_t tx_data;
    logic      transmit_empty;
    logic      transmit_start;
    logic      transmit_response;
    logic      fifo_full;
    logic      overflow_err;

    modport master (
        output wr_data, write_enable, packet_commit, packet_abort, read_enable,
        input  tx_data, transmit_empty, transmit_start, transmit_response,
               fifo_full, overflow_err
    );

    modport slave (
        input  wr_data, write_enable, packet_commit, packet_abort, read_enable,
        output tx_data, transmit_empty, transmit_start, transmit_response,
               fifo_full, overflow_err
    );
endinterface

// File: rtl/usb_pkt_len_queue.sv
// usb_pkt_len_queue: small FIFO of committed packet lengths.
//   clk, n_rst      - clock, async active-low reset
//   push, len_in    - enqueue a length (ignored when full)
//   pop             - drop the head length (ignored when empty)
//   len_out         - head length, valid while !empty
//   empty, full     - occupancy flags
module usb_pkt_len_queue #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] len_in,
    output logic [WIDTH-1:0] len_out,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign len_out = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= len_in;
    end
endmodule

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: packet-framed transmit buffer in front of the USB TX path.
//   clk, n_rst - clock, async active-low reset
//   bus        - usb_tx_fifo_if.slave: writes/commit/abort from the producer,
//                head word, pop, start pulse and status for the transmitter
//
// Sequencer states:
//   state | meaning
//   IDLE  | waiting for a committed packet in the length queue
//   START | one-cycle transmit_start pulse, packet length loaded
//   SEND  | head word exposed, popped by read_enable until rem_cnt hits 0
//   GAP   | CRC/EOP/inter-packet guard, GAP_CYCLES long
module usb_tx_fifo
    import usb_tx_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int PKT_DEPTH  = 4,
    parameter int GAP_CYCLES = 512
) (
    input  logic          clk,
    input  logic          n_rst,
    usb_tx_fifo_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_SEND  = SEND;
    localparam logic [1:0] ST_GAP   = GAP;

    usb_word_t         mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cm_ptr_q, cm_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // Uncommitted length is kept separately: wr_ptr-cm_ptr cannot tell 0 from DEPTH.
    logic [CNT_W-1:0]  unc_q, unc_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [1:0]        state_q, state_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full, tx_empty;
    logic              wr_acc, pop, q_push, q_pop, q_empty, q_full;
    logic [CNT_W-1:0]  unc_plus, q_len_out;

    usb_pkt_len_queue #(
        .WIDTH (CNT_W),
        .DEPTH (PKT_DEPTH)
    ) u_len_queue (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (q_push),
        .pop     (q_pop),
        .len_in  (unc_plus),
        .len_out (q_len_out),
        .empty   (q_empty),
        .full    (q_full)
    );

    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign tx_empty  = !((state_q == ST_SEND) && (rem_q != '0));

    // Abort discards the same-cycle write, so it is masked out of wr_acc.
    assign wr_acc    = bus.write_enable && !fifo_full && !bus.packet_abort;
    assign unc_plus  = unc_q + CNT_W'(wr_acc);

    // Producer side: writes, commit, abort, occupancy and error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        unc_d    = unc_q;
        ovf_d    = ovf_q;
        q_push   = 1'b0;
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
        if (bus.packet_abort) begin
            wr_ptr_d = cm_ptr_q;
            unc_d    = '0;
            count_d  = count_d - unc_q;
            ovf_d    = 1'b0;
        end else begin
            if (bus.write_enable && fifo_full) ovf_d = 1'b1;
            if (bus.packet_commit && (unc_plus != '0)) begin
                unc_d = '0;
                if (q_full) begin
                    // No room for another length: drop the whole open packet.
                    wr_ptr_d = cm_ptr_q;
                    count_d  = count_d - unc_plus;
                    ovf_d    = 1'b1;
                end else begin
                    q_push   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
                    cm_ptr_d = wr_ptr_d;
                end
            end else begin
                unc_d    = unc_plus;
                wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
            end
        end
    end

    // Transmit sequencer.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        rd_ptr_d = rd_ptr_q;
        q_pop    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop   = 1'b1;
                    rem_d   = q_len_out;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_SEND;
            ST_SEND: begin
                if (bus.read_enable && (rem_q != '0)) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    rem_d    = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unc_q    <= '0;
            rem_q    <= '0;
            gap_q    <= '0;
            state_q  <= ST_IDLE;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unc_q    <= unc_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // Head word is forced to zero while nothing is exposed so reset/idle read 0.
    assign bus.tx_data           = tx_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.transmit_empty    = tx_empty;
    assign bus.transmit_start    = (state_q == ST_START);
    assign bus.transmit_response = 1'b0;
    assign bus.fifo_full         = fifo_full;
    assign bus.overflow_err      = ovf_q;
endmodule
